oled_page_sequencer: RTL and testbench

OLED_PAGE_SEQUENCER -- requirements
Module: oled_page_sequencer

---
 rtl/oled_pkg.sv | 17 +
 rtl/oled_cycle_timer.sv | 28 ++
 rtl/oled_page_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_oled_page_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared definitions for the OLED page sequencer: sequencer states and
// the page/row/character widths of the 4-row x 16-char text pages.
package oled_pkg;

  localparam int CHAR_W = 8;
  localparam int ROW_W  = 16 * CHAR_W;
  localparam int PAGE_W = 4 * ROW_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_RELEASE,
    ST_DWELL
  } state_t;

endpackage

// File: rtl/oled_cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Loading N-1 and enabling from the next cycle gives an N-cycle window.
module oled_cycle_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/oled_page_sequencer.sv
// Cycles buffered text pages through an OLED display driver with dwell and
// driver-timeout handling. Optional macro OLED_PAGE_SEQ_SKIP_EN skips resending unchanged pages.
module oled_page_sequencer
  import oled_pkg::*;
#(
  parameter int PAGES       = 2,
  parameter int DWELL_CYC   = 100000000,
  parameter int TIMEOUT_CYC = 10000000,
  localparam int PIW        = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PAGES*512-1:0]  msg,
  input  logic                  msg_valid,
  output logic [511:0]          disp_rows,
  output logic                  disp_enable,
  input  logic                  disp_done,
  output logic                  busy,
  output logic [PIW-1:0]        page_idx,
  output logic                  timeout_err,
  output logic [15:0]           upd_cnt
);

  localparam int MAX_CYC = (DWELL_CYC > TIMEOUT_CYC) ? DWELL_CYC : TIMEOUT_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0]  DWELL_LOAD   = TW'(DWELL_CYC - 1);
  localparam logic [TW-1:0]  TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [PIW-1:0] PAGE_LAST    = PIW'(PAGES - 1);

  state_t                    state_reg, state_next;
  logic [PAGES*PAGE_W-1:0]   buffer_reg, buffer_next;
  logic [PAGE_W-1:0]         rows_reg, rows_next;
  logic [PIW-1:0]            page_reg, page_next;
  logic                      pending_reg, pending_next;
  logic                      timeout_reg, timeout_next;
  logic [15:0]               upd_reg, upd_next;

  logic                      timer_load, timer_enable, timer_expired;
  logic [TW-1:0]             timer_value;
  logic                      skip_hit;

  logic [PAGE_W-1:0]         page_arr [PAGES];
  logic [PAGE_W-1:0]         page_data;

  // Page 0 sits in the most significant slice of the buffer.
  for (genvar gi = 0; gi < PAGES; gi++) begin : g_page
    assign page_arr[gi] = buffer_reg[(PAGES-gi)*PAGE_W-1 -: PAGE_W];
  end
  assign page_data = page_arr[page_reg];

  oled_cycle_timer #(.WIDTH(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .enable     (timer_enable),
    .expired    (timer_expired)
  );

`ifdef OLED_PAGE_SEQ_SKIP_EN
  logic [PAGE_W-1:0] last_reg;
  logic              last_ok_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_reg    <= '0;
      last_ok_reg <= 1'b0;
    end else if (state_reg == ST_SEND) begin
      if (disp_done) begin
        last_reg    <= rows_reg;
        last_ok_reg <= 1'b1;
      end else if (timer_expired) begin
        last_ok_reg <= 1'b0;
      end
    end
  end

  assign skip_hit = last_ok_reg && (page_data == last_reg);
`else
  assign skip_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      buffer_reg  <= '0;
      rows_reg    <= '0;
      page_reg    <= '0;
      pending_reg <= 1'b0;
      timeout_reg <= 1'b0;
      upd_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      buffer_reg  <= buffer_next;
      rows_reg    <= rows_next;
      page_reg    <= page_next;
      pending_reg <= pending_next;
      timeout_reg <= timeout_next;
      upd_reg     <= upd_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    buffer_next  = buffer_reg;
    rows_next    = rows_reg;
    page_next    = page_reg;
    pending_next = pending_reg;
    timeout_next = timeout_reg;
    upd_next     = upd_reg;
    timer_load   = 1'b0;
    timer_value  = DWELL_LOAD;
    timer_enable = 1'b0;

    if (msg_valid) begin
      buffer_next = msg;
      if (state_reg inside {ST_LOAD, ST_SEND, ST_RELEASE}) pending_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (msg_valid) begin
          page_next  = '0;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        rows_next = page_data;
        if (skip_hit) begin
          // Entering DWELL with a pending message restarts at page 0 instead.
          if (pending_next) begin
            page_next    = '0;
            pending_next = 1'b0;
            state_next   = ST_LOAD;
          end else begin
            timer_load = 1'b1;
            state_next = ST_DWELL;
          end
        end else begin
          timer_load  = 1'b1;
          timer_value = TIMEOUT_LOAD;
          state_next  = ST_SEND;
        end
      end
      ST_SEND: begin
        timer_enable = 1'b1;
        if (disp_done) begin
          upd_next   = upd_reg + 16'd1;
          state_next = ST_RELEASE;
        end else if (timer_expired) begin
          timeout_next = 1'b1;
          state_next   = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!disp_done) begin
          if (pending_next) begin
            page_next    = '0;
            pending_next = 1'b0;
            state_next   = ST_LOAD;
          end else begin
            timer_load = 1'b1;
            state_next = ST_DWELL;
          end
        end
      end
      ST_DWELL: begin
        timer_enable = 1'b1;
        if (msg_valid) begin
          page_next  = '0;
          state_next = ST_LOAD;
        end else if (timer_expired) begin
          page_next  = (page_reg == PAGE_LAST) ? '0 : page_reg + 1'b1;
          state_next = ST_LOAD;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign disp_rows   = rows_reg;
  assign disp_enable = (state_reg == ST_SEND);
  assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_DWELL);
  assign page_idx    = page_reg;
  assign timeout_err = timeout_reg;
  assign upd_cnt     = upd_reg;

endmodule

// File: tb/tb_oled_page_sequencer.sv
// Bench for oled_page_sequencer (PAGES=2, DWELL_CYC=8, TIMEOUT_CYC=20) with a
// behavioural display driver and a scoreboard of expected page updates.
module tb_oled_page_sequencer;

  localparam int LIMIT = 200;

  typedef struct packed {
    logic [511:0] rows;
    logic [0:0]   idx;
    logic [15:0]  upd;
    logic         terr;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1023:0] msg = '0;
  logic          msg_valid = 1'b0;
  logic [511:0]  disp_rows;
  logic          disp_enable;
  logic          disp_done = 1'b0;
  logic          busy;
  logic [0:0]    page_idx;
  logic          timeout_err;
  logic [15:0]   upd_cnt;

  int   checks = 0;
  int   passed = 0;
  bit   respond = 1'b0;
  int   drv_cnt = 0;
  exp_t sb[$];

  logic [511:0] page_a, page_b, page_c, page_d, page_e;

  oled_page_sequencer #(.PAGES(2), .DWELL_CYC(8), .TIMEOUT_CYC(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .msg         (msg),
    .msg_valid   (msg_valid),
    .disp_rows   (disp_rows),
    .disp_enable (disp_enable),
    .disp_done   (disp_done),
    .busy        (busy),
    .page_idx    (page_idx),
    .timeout_err (timeout_err),
    .upd_cnt     (upd_cnt)
  );

  always #5 clk = ~clk;

  // Driver model: done rises on the third cycle of enable, drops once enable falls.
  always @(negedge clk) begin
    if (!disp_enable) begin
      drv_cnt   = 0;
      disp_done = 1'b0;
    end else begin
      drv_cnt++;
      if (respond && drv_cnt >= 3) disp_done = 1'b1;
    end
  end

  task automatic apply_reset();
    reset = 1'b0;
    msg_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb.delete();
  endtask

  task automatic pulse_msg(input logic [1023:0] m);
    msg = m;
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
  endtask

  // Waits for one enable pulse; lo/hi are negedge samples with enable low/high.
  task automatic wait_update(input bit inject, input logic [1023:0] new_msg,
                             output int lo, output int hi, output bit ok);
    lo = 0;
    hi = 0;
    while (!disp_enable && lo < LIMIT) begin
      lo++;
      @(negedge clk);
    end
    while (disp_enable && hi < LIMIT) begin
      if (inject && hi == 0) begin
        msg = new_msg;
        msg_valid = 1'b1;
      end
      hi++;
      @(negedge clk);
      msg_valid = 1'b0;
    end
    ok = (lo < LIMIT) && (hi < LIMIT);
    $display("update: rows[511:504]=%h page_idx=%0d upd_cnt=%0d timeout_err=%0b en_cycles=%0d gap=%0d",
             disp_rows[511:504], page_idx, upd_cnt, timeout_err, hi, lo);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (disp_enable !== 1'b0) $display("FAIL reset_enable got %b want 0", disp_enable); else passed++;
    checks++; if (disp_rows !== '0) $display("FAIL reset_rows got %h want 0", disp_rows); else passed++;
    checks++; if (page_idx !== 1'b0) $display("FAIL reset_page got %0d want 0", page_idx); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (timeout_err !== 1'b0) $display("FAIL reset_terr got %b want 0", timeout_err); else passed++;
    checks++; if (upd_cnt !== 16'd0) $display("FAIL reset_upd got %0d want 0", upd_cnt); else passed++;
  endtask

  task automatic test_basic();
    int lo, hi; bit ok; exp_t e, act;
    apply_reset();
    respond = 1'b1;
    sb.push_back('{page_a, 1'b0, 16'd1, 1'b0});
    sb.push_back('{page_b, 1'b1, 16'd2, 1'b0});
    sb.push_back('{page_a, 1'b0, 16'd3, 1'b0});
    pulse_msg({page_a, page_b});
    for (int n = 0; n < 3; n++) begin
      wait_update(1'b0, '0, lo, hi, ok);
      checks++;
      if (!ok) begin $display("FAIL basic_wait got lo=%0d hi=%0d want both < %0d", lo, hi, LIMIT); break; end
      passed++;
      e = sb.pop_front();
      act = '{disp_rows, page_idx, upd_cnt, timeout_err};
      checks++; if (act !== e) $display("FAIL basic_update%0d got %h want %h", n, act, e); else passed++;
      checks++; if (hi !== 3) $display("FAIL basic_enable_len%0d got %0d want 3", n, hi); else passed++;
      if (n > 0) begin
        checks++; if (lo !== 10) $display("FAIL basic_dwell_gap%0d got %0d want 10", n, lo); else passed++;
      end
    end
  endtask

  task automatic test_timeout();
    int lo, hi; bit ok; exp_t e, act;
    apply_reset();
    respond = 1'b0;
    sb.push_back('{page_a, 1'b0, 16'd0, 1'b1});
    sb.push_back('{page_b, 1'b1, 16'd0, 1'b1});
    pulse_msg({page_a, page_b});
    for (int n = 0; n < 2; n++) begin
      wait_update(1'b0, '0, lo, hi, ok);
      checks++;
      if (!ok) begin $display("FAIL timeout_wait got lo=%0d hi=%0d want both < %0d", lo, hi, LIMIT); break; end
      passed++;
      e = sb.pop_front();
      act = '{disp_rows, page_idx, upd_cnt, timeout_err};
      checks++; if (act !== e) $display("FAIL timeout_update%0d got %h want %h", n, act, e); else passed++;
      checks++; if (hi !== 20) $display("FAIL timeout_enable_len%0d got %0d want 20", n, hi); else passed++;
      if (n > 0) begin
        checks++; if (lo !== 10) $display("FAIL timeout_dwell_gap got %0d want 10", lo); else passed++;
      end
    end
  endtask

  task automatic test_mid_update();
    int lo, hi; bit ok, inj; exp_t e, act;
    int want_gap [4] = '{-1, 10, 2, 10};
    apply_reset();
    respond = 1'b1;
    sb.push_back('{page_a, 1'b0, 16'd1, 1'b0});
    sb.push_back('{page_b, 1'b1, 16'd2, 1'b0});
    pulse_msg({page_a, page_b});
    for (int n = 0; n < 4; n++) begin
      inj = (n == 1);
      if (inj) begin
        sb.push_back('{page_c, 1'b0, 16'd3, 1'b0});
        sb.push_back('{page_d, 1'b1, 16'd4, 1'b0});
      end
      wait_update(inj, {page_c, page_d}, lo, hi, ok);
      checks++;
      if (!ok) begin $display("FAIL mid_wait got lo=%0d hi=%0d want both < %0d", lo, hi, LIMIT); break; end
      passed++;
      e = sb.pop_front();
      act = '{disp_rows, page_idx, upd_cnt, timeout_err};
      checks++; if (act !== e) $display("FAIL mid_update%0d got %h want %h", n, act, e); else passed++;
      if (n > 0) begin
        checks++; if (lo !== want_gap[n]) $display("FAIL mid_gap%0d got %0d want %0d", n, lo, want_gap[n]); else passed++;
      end
    end
  endtask

  task automatic test_reset_in_send();
    int lo, hi, n; bit ok;
    apply_reset();
    respond = 1'b1;
    pulse_msg({page_a, page_b});
    wait_update(1'b0, '0, lo, hi, ok);
    n = 0;
    while (!disp_enable && n < LIMIT) begin n++; @(negedge clk); end
    checks++; if (!disp_enable) $display("FAIL rst_send_reach got enable=%b want 1", disp_enable); else passed++;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++; if (disp_enable !== 1'b0) $display("FAIL rst_enable got %b want 0", disp_enable); else passed++;
    checks++; if (disp_rows !== '0) $display("FAIL rst_rows got %h want 0", disp_rows); else passed++;
    checks++; if (page_idx !== 1'b0) $display("FAIL rst_page got %0d want 0", page_idx); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
    checks++; if (timeout_err !== 1'b0) $display("FAIL rst_terr got %b want 0", timeout_err); else passed++;
    checks++; if (upd_cnt !== 16'd0) $display("FAIL rst_upd got %0d want 0", upd_cnt); else passed++;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (disp_enable) n++;
    end
    checks++; if (n !== 0) $display("FAIL rst_idle_enable got %0d high cycles want 0", n); else passed++;
  endtask

  task automatic test_skip();
    int lo, hi, n; bit ok; exp_t e, act;
    apply_reset();
    respond = 1'b1;
    sb.push_back('{page_e, 1'b0, 16'd1, 1'b0});
`ifndef OLED_PAGE_SEQ_SKIP_EN
    sb.push_back('{page_e, 1'b1, 16'd2, 1'b0});
`endif
    pulse_msg({page_e, page_e});
    while (sb.size() > 0) begin
      wait_update(1'b0, '0, lo, hi, ok);
      checks++;
      if (!ok) begin $display("FAIL skip_wait got lo=%0d hi=%0d want both < %0d", lo, hi, LIMIT); break; end
      passed++;
      e = sb.pop_front();
      act = '{disp_rows, page_idx, upd_cnt, timeout_err};
      checks++; if (act !== e) $display("FAIL skip_update got %h want %h", act, e); else passed++;
    end
`ifdef OLED_PAGE_SEQ_SKIP_EN
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (disp_enable) n++;
    end
    checks++; if (n !== 0) $display("FAIL skip_enable got %0d high cycles want 0", n); else passed++;
    checks++; if (upd_cnt !== 16'd1) $display("FAIL skip_upd got %0d want 1", upd_cnt); else passed++;
`endif
  endtask

  initial begin
    page_a = {64{8'h41}};
    page_b = {64{8'h42}};
    page_c = {64{8'h43}};
    page_d = {64{8'h44}};
    page_e = {64{8'h45}};
    @(negedge clk);
    test_reset();
    test_basic();
    test_timeout();
    test_mid_update();
    test_reset_in_send();
    test_skip();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
